wic_wakeup_ctrl: RTL and testbench
==================================

WIC_WAKEUP_CTRL -- requirements
Module: wic_wakeup_ctrl

Interface
REQ-001 SHALL have parameter NUM_INT, default 32: number of wic interrupt cells aggregated (2..64).
REQ-002 SHALL have parameter STABLE_CYC, default 16: post-clock-stable settle cycles (1..255).
REQ-003 wic_clk  in  1  sole clock; all state on its rising edge.
REQ-004 pad_cpu_rst  in  1  reset; asynchronous, active-high.
REQ-005 int_pending  in  NUM_INT  per-cell int_pending outputs.
REQ-006 wic_awake_en  in  NUM_INT  per-cell wakeup enables.
REQ-007 cpu_sleep_req  in  1  level from CPU after WFI; held until woken.
REQ-008 pmu_clk_stable  in  1  level from PMU: core clock restarted and stable.
REQ-009 cpu_clk_en  out  1  core clock-gate enable.
REQ-010 wic_sleep_ack  out  1  sleep granted, core clock gated.
REQ-011 pmu_wakeup_req  out  1  request to PMU to restore the core clock.
REQ-012 wic_int_vld  out  1  one-cycle pulse: wakeup source valid.
REQ-013 wic_int_id  out  clog2(NUM_INT)  index of the winning wakeup source.
REQ-014 pending_clr  out  NUM_INT  one-hot, one-cycle clear to the winning cell.

Function
REQ-015 Wake condition: wake_vec = int_pending & wic_awake_en; wake_any = OR of wake_vec.
REQ-016 Winner is the lowest set index of wake_vec.
REQ-017 FSM states: IDLE, SLEEP, WAKE_REQ, STABLE, RESUME; all outputs decoded from registered state/regs (Moore).
REQ-018 IDLE->SLEEP when cpu_sleep_req rises (req=1, req_ff=0) and wake_any=0.
REQ-019 On a rising cpu_sleep_req with wake_any=1, FSM stays IDLE; no ack and no pulse; CPU re-arms by dropping the request.
REQ-020 SLEEP: cpu_clk_en=0 and wic_sleep_ack=1.
REQ-021 SLEEP->WAKE_REQ when wake_any=1; winner index latched into wic_int_id on the same edge.
REQ-022 SLEEP->IDLE when cpu_sleep_req=0 (abort) and wake_any=0; no pending_clr, no wic_int_vld.
REQ-023 WAKE_REQ: pmu_wakeup_req=1, cpu_clk_en=0, wic_sleep_ack=1.
REQ-024 WAKE_REQ->STABLE on first cycle with pmu_clk_stable=1, including when it is already high on entry.
REQ-025 STABLE loads an 8-bit counter with STABLE_CYC-1 and decrements it; at 0 it moves to RESUME, so STABLE lasts exactly STABLE_CYC cycles.
REQ-026 STABLE: pmu_wakeup_req=0, cpu_clk_en=0, wic_sleep_ack=0.
REQ-027 A pmu_clk_stable drop during STABLE SHALL return the FSM to WAKE_REQ; the counter reloads on the next stable.
REQ-028 RESUME lasts one cycle, then IDLE: cpu_clk_en=1, wic_int_vld=1, pending_clr[wic_int_id]=1.
REQ-029 The latched wic_int_id holds until the next SLEEP->WAKE_REQ, even if its source drops mid-wake; wakeup still completes.
REQ-030 Latency: wake_any at SLEEP cycle t gives pmu_wakeup_req at t+1; pmu_clk_stable at cycle u in WAKE_REQ gives wic_int_vld at u+1+STABLE_CYC.
REQ-031 cpu_clk_en=1 in IDLE and RESUME only.

Reset
REQ-032 Asserting pad_cpu_rst at any time SHALL force IDLE, counter=0, req_ff=0, wic_int_id=0, cpu_clk_en=1, and all other outputs 0.
REQ-033 If cpu_sleep_req is high when pad_cpu_rst releases, a sleep entry follows (rising-edge rule, req_ff=0).

Structure
REQ-034 Package wic_pkg SHALL hold the FSM state encoding, the counter width (8), and the NUM_INT/STABLE_CYC defaults.
REQ-035 The lowest-index priority encoder SHALL be the sub-module wic_prio_enc (combinational: vector in, index + valid out).

Verification (NUM_INT=32, STABLE_CYC=4)
REQ-036 Req rises, wake_vec=0; pending[5]&en[5] set 3 cycles later; stable tied high -> sleep_ack next cycle, wakeup_req 1 cycle, vld after 4 STABLE cycles, id=5, pending_clr=0x20.
REQ-037 pending bits 3,9,17 with enables 9,17 set together during SLEEP -> id=9, pending_clr=0x200.
REQ-038 Req rises with pending[0]&en[0]=1 -> stays IDLE, cpu_clk_en=1, no ack, no vld.
REQ-039 In SLEEP, drop cpu_sleep_req with no wake -> IDLE next cycle, cpu_clk_en=1, no pending_clr.
REQ-040 Stable drops in the 2nd STABLE cycle, returns 5 cycles later -> back to WAKE_REQ (wakeup_req=1), then a full 4-cycle STABLE, then RESUME.
REQ-041 Assert reset in WAKE_REQ -> immediately cpu_clk_en=1, wakeup_req=0, ack=0; after release with req high -> SLEEP re-entered.

Source files
------------

// File: rtl/wic_pkg.sv
// Shared definitions for the WIC wakeup controller.
// FSM encoding, counter width and default sizing.
package wic_pkg;

  localparam int NUM_INT_DEF    = 32;
  localparam int STABLE_CYC_DEF = 16;
  localparam int CNT_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLEEP,
    ST_WAKE_REQ,
    ST_STABLE,
    ST_RESUME
  } wic_state_e;

endpackage

// File: rtl/wic_prio_enc.sv
// Lowest-index priority encoder over the wake vector.
// Purely combinational: index of lowest set bit plus any-set flag.
module wic_prio_enc #(
  parameter int N = 32,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         vld
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign vld = |vec;

endmodule

// File: rtl/wic_wakeup_ctrl.sv
// WIC wakeup controller: sleep handshake, PMU clock restore,
// settle timing and wakeup-source reporting.
module wic_wakeup_ctrl
  import wic_pkg::*;
#(
  parameter int NUM_INT    = NUM_INT_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  localparam int IW        = $clog2(NUM_INT)
) (
  input  logic               wic_clk,
  input  logic               pad_cpu_rst,
  input  logic [NUM_INT-1:0] int_pending,
  input  logic [NUM_INT-1:0] wic_awake_en,
  input  logic               cpu_sleep_req,
  input  logic               pmu_clk_stable,
  output logic               cpu_clk_en,
  output logic               wic_sleep_ack,
  output logic               pmu_wakeup_req,
  output logic               wic_int_vld,
  output logic [IW-1:0]      wic_int_id,
  output logic [NUM_INT-1:0] pending_clr
);

  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(STABLE_CYC - 1);

  wic_state_e         state;
  logic               req_ff;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_INT-1:0] wake_vec;
  logic [IW-1:0]      win_id;
  logic               wake_any;

  assign wake_vec = int_pending & wic_awake_en;

  wic_prio_enc #(
    .N (NUM_INT),
    .W (IW)
  ) u_prio_enc (
    .vec (wake_vec),
    .idx (win_id),
    .vld (wake_any)
  );

  always_ff @(posedge wic_clk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      state      <= ST_IDLE;
      req_ff     <= 1'b0;
      cnt        <= '0;
      wic_int_id <= '0;
    end else begin
      req_ff <= cpu_sleep_req;
      unique case (state)
        ST_IDLE: begin
          if (cpu_sleep_req && !req_ff && !wake_any)
            state <= ST_SLEEP;
        end
        ST_SLEEP: begin
          if (wake_any) begin
            state      <= ST_WAKE_REQ;
            wic_int_id <= win_id;
          end else if (!cpu_sleep_req) begin
            state <= ST_IDLE;
          end
        end
        ST_WAKE_REQ: begin
          if (pmu_clk_stable) begin
            state <= ST_STABLE;
            cnt   <= CNT_LD;
          end
        end
        ST_STABLE: begin
          // Losing the clock restarts the whole settle window.
          if (!pmu_clk_stable)
            state <= ST_WAKE_REQ;
          else if (cnt == '0)
            state <= ST_RESUME;
          else
            cnt <= cnt - 1'b1;
        end
        ST_RESUME: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_clk_en     = (state == ST_IDLE) ||
                          (state == ST_RESUME);
  assign wic_sleep_ack  = (state == ST_SLEEP) ||
                          (state == ST_WAKE_REQ);
  assign pmu_wakeup_req = (state == ST_WAKE_REQ);
  assign wic_int_vld    = (state == ST_RESUME);
  assign pending_clr    = wic_int_vld ?
                          (NUM_INT'(1) << wic_int_id) : '0;

endmodule

// File: tb/tb_wic_wakeup_ctrl.sv
// Scoreboard bench for wic_wakeup_ctrl (NUM_INT=32, STABLE_CYC=4).
// Randomized wake scenarios against a spec-level reference model.
module tb_wic_wakeup_ctrl;

  localparam int N  = 32;
  localparam int S  = 4;
  localparam int IW = $clog2(N);

  logic          wic_clk = 1'b0;
  logic          pad_cpu_rst = 1'b1;
  logic [N-1:0]  int_pending = '0;
  logic [N-1:0]  wic_awake_en = '0;
  logic          cpu_sleep_req = 1'b0;
  logic          pmu_clk_stable = 1'b0;
  logic          cpu_clk_en;
  logic          wic_sleep_ack;
  logic          pmu_wakeup_req;
  logic          wic_int_vld;
  logic [IW-1:0] wic_int_id;
  logic [N-1:0]  pending_clr;

  wic_wakeup_ctrl #(
    .NUM_INT    (N),
    .STABLE_CYC (S)
  ) dut (
    .wic_clk        (wic_clk),
    .pad_cpu_rst    (pad_cpu_rst),
    .int_pending    (int_pending),
    .wic_awake_en   (wic_awake_en),
    .cpu_sleep_req  (cpu_sleep_req),
    .pmu_clk_stable (pmu_clk_stable),
    .cpu_clk_en     (cpu_clk_en),
    .wic_sleep_ack  (wic_sleep_ack),
    .pmu_wakeup_req (pmu_wakeup_req),
    .wic_int_vld    (wic_int_vld),
    .wic_int_id     (wic_int_id),
    .pending_clr    (pending_clr)
  );

  always #5 wic_clk = ~wic_clk;

  typedef struct {
    int           id;
    logic [N-1:0] clr;
    int           at;
  } exp_t;

  exp_t sb[$];
  bit   plan[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge wic_clk) cyc++;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int lowest(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor: every wakeup pulse must match the oldest expectation.
  always @(negedge wic_clk) begin
    exp_t e;
    if (!pad_cpu_rst) begin
      if (wic_int_vld) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_vld: got id %0d expected no pulse",
                   wic_int_id);
        end else begin
          e = sb.pop_front();
          chk("int_id", 64'(wic_int_id), 64'(e.id));
          chk("pending_clr", 64'(pending_clr), 64'(e.clr));
          chk("vld_cycle", 64'(cyc), 64'(e.at));
        end
      end else begin
        chk("clr_quiet", 64'(pending_clr), 64'(0));
      end
    end
  end

  task automatic step();
    @(negedge wic_clk);
  endtask

  task automatic chk_out(string nm, bit en, bit ack, bit wreq);
    chk({nm, "_clk_en"}, 64'(cpu_clk_en), 64'(en));
    chk({nm, "_ack"}, 64'(wic_sleep_ack), 64'(ack));
    chk({nm, "_wreq"}, 64'(pmu_wakeup_req), 64'(wreq));
  endtask

  // plan[i] is pmu_clk_stable at the i-th edge after WAKE_REQ entry.
  task automatic build_plan(int mode);
    plan.delete();
    if (mode >= 1) repeat ($urandom_range(1, 4)) plan.push_back(1'b0);
    if (mode == 2) begin
      repeat ($urandom_range(1, S)) plan.push_back(1'b1);
      repeat ($urandom_range(1, 5)) plan.push_back(1'b0);
    end
    repeat (S + 1) plan.push_back(1'b1);
  endtask

  task automatic wake_run(logic [N-1:0] pend, logic [N-1:0] en,
                          int sdly, bit drop);
    exp_t e;
    int   r;
    int   iend;
    int_pending   = '0;
    wic_awake_en  = '0;
    cpu_sleep_req = 1'b1;
    step();
    chk_out("sleep", 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < sdly; k++) begin
      step();
      chk_out("sleep_hold", 1'b0, 1'b1, 1'b0);
    end
    int_pending    = pend;
    wic_awake_en   = en;
    pmu_clk_stable = plan[0];
    // Resume follows the first run of S+1 consecutive stable edges.
    r    = 0;
    iend = -1;
    for (int i = 0; i < plan.size(); i++) begin
      r = plan[i] ? r + 1 : 0;
      if (r == S + 1 && iend < 0) iend = i;
    end
    e.id  = lowest(pend & en);
    e.clr = N'(1) << e.id;
    e.at  = cyc + 2 + iend;
    sb.push_back(e);
    step();
    chk_out("wake_req", 1'b0, 1'b1, 1'b1);
    if (drop) int_pending = '0;
    r = 0;
    for (int i = 0; i <= iend; i++) begin
      pmu_clk_stable = plan[i];
      step();
      r = plan[i] ? r + 1 : 0;
      chk_out("wake_phase", r == S + 1, r == 0, r == 0);
    end
    cpu_sleep_req  = 1'b0;
    int_pending    = '0;
    wic_awake_en   = '0;
    pmu_clk_stable = 1'b0;
    step();
    chk_out("back_idle", 1'b1, 1'b0, 1'b0);
    chk("back_idle_vld", 64'(wic_int_vld), 64'(0));
    step();
  endtask

  initial begin
    logic [N-1:0] p;
    logic [N-1:0] m;
    int           b;
    repeat (3) step();
    chk_out("reset", 1'b1, 1'b0, 1'b0);
    chk("reset_vld", 64'(wic_int_vld), 64'(0));
    chk("reset_id", 64'(wic_int_id), 64'(0));
    chk("reset_clr", 64'(pending_clr), 64'(0));
    pad_cpu_rst = 1'b0;
    step();

    // Single source, stable tied high.
    build_plan(0);
    wake_run(32'h20, 32'h20, 3, 1'b0);

    // Several pending, only some enabled.
    build_plan(0);
    wake_run(32'h0002_0208, 32'h0002_0200, 1, 1'b0);

    // Wake already present when the request rises: no sleep.
    int_pending   = 32'h1;
    wic_awake_en  = 32'h1;
    cpu_sleep_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out("no_sleep", 1'b1, 1'b0, 1'b0);
    end
    cpu_sleep_req = 1'b0;
    int_pending   = '0;
    wic_awake_en  = '0;
    step();

    // Abort from SLEEP.
    cpu_sleep_req = 1'b1;
    step();
    chk_out("abort_sleep", 1'b0, 1'b1, 1'b0);
    cpu_sleep_req = 1'b0;
    step();
    chk_out("abort_idle", 1'b1, 1'b0, 1'b0);
    step();

    // Clock drops in the 2nd settle cycle, returns 5 edges later.
    plan = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    wake_run(32'h0000_4000, 32'h0000_4000, 0, 1'b0);

    // Source vanishes mid-wake; latched id still reported.
    build_plan(1);
    wake_run(32'h0080_0000, 32'hFF80_0000, 2, 1'b1);

    // Reset while in WAKE_REQ.
    cpu_sleep_req  = 1'b1;
    pmu_clk_stable = 1'b0;
    step();
    int_pending  = 32'h80;
    wic_awake_en = 32'h80;
    step();
    chk_out("rst_wreq", 1'b0, 1'b1, 1'b1);
    chk("rst_wreq_id", 64'(wic_int_id), 64'(7));
    int_pending  = '0;
    wic_awake_en = '0;
    #2 pad_cpu_rst = 1'b1;
    #1;
    chk_out("rst_async", 1'b1, 1'b0, 1'b0);
    chk("rst_async_id", 64'(wic_int_id), 64'(0));
    step();
    pad_cpu_rst = 1'b0;
    step();
    chk_out("rst_reenter", 1'b0, 1'b1, 1'b0);
    cpu_sleep_req = 1'b0;
    step();
    chk_out("rst_exit", 1'b1, 1'b0, 1'b0);
    step();

    for (int t = 0; t < 40; t++) begin
      p = N'($urandom);
      m = N'($urandom) & N'($urandom);
      b = $urandom_range(0, N - 1);
      p[b] = 1'b1;
      m[b] = 1'b1;
      build_plan($urandom_range(0, 2));
      wake_run(p, m, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) step();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
